// File: rtl/irq_pkg.sv
// Shared types and default sizing for the IRQ acceptance controller.
package irq_pkg;

    localparam int IRQ_NUM_DEF      = 8;
    localparam int IRQ_VEC_BASE_DEF = 64;
    localparam int IRQ_VEC_W_DEF    = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CPU_REQ = 3'd1,
        ST_DTC_REQ = 3'd2,
        ST_CPU_ACK = 3'd3,
        ST_DTC_ACK = 3'd4
    } irq_acc_state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder with a valid flag.
module irq_prio_enc #(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        valid = |req;
        idx   = {IDX_W{1'b0}};
        for (int i = N - 1; i >= 0; i--) begin
            idx = req[i] ? IDX_W'(i) : idx;
        end
    end

endmodule

// File: rtl/irq_accept_ctrl.sv
// Interrupt acceptance controller: fixed-priority arbitration, CPU req/ack and DTC hand-off.
// Optional DTC path is built only when IRQ_ACCEPT_DTC_EN is defined.
module irq_accept_ctrl
    import irq_pkg::*;
#(
    parameter int NUM_IRQ  = IRQ_NUM_DEF,
    parameter int VEC_BASE = IRQ_VEC_BASE_DEF,
    parameter int VEC_W    = IRQ_VEC_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_IRQ-1:0]         irq_flag,
    input  logic [NUM_IRQ-1:0]         irq_enable,
    input  logic [NUM_IRQ-1:0]         dtc_enable,
    input  logic                       cpu_int_mask,
    input  logic                       cpu_int_ack,
    input  logic                       dtc_done,
    output logic                       int_req,
    output logic [VEC_W-1:0]           int_vec,
    output logic                       dtc_req,
    output logic                       exc_handling,
    output logic                       dtc_activate,
    output logic [$clog2(NUM_IRQ)-1:0] active_id,
    output logic                       busy
);

    localparam int ID_W = $clog2(NUM_IRQ);

    irq_acc_state_t   state_q, state_d;
    logic [ID_W-1:0]  active_id_q, active_id_d;
    logic             int_req_q, int_req_d;
    logic [VEC_W-1:0] int_vec_q, int_vec_d;
    logic             dtc_req_q, dtc_req_d;
    logic             exc_handling_q, exc_handling_d;
    logic             dtc_activate_q, dtc_activate_d;
    logic             busy_q, busy_d;

    logic [NUM_IRQ-1:0] elig_s;
    logic               win_valid_s;
    logic [ID_W-1:0]    win_id_s;

    function automatic logic [VEC_W-1:0] vec_of(input logic [ID_W-1:0] id);
        return VEC_W'(VEC_BASE) + VEC_W'(id);
    endfunction

`ifdef IRQ_ACCEPT_DTC_EN
    // A DTC-routed channel stays eligible while the CPU is masked.
    assign elig_s = irq_flag & irq_enable & (dtc_enable | {NUM_IRQ{~cpu_int_mask}});
`else
    logic dtc_unused_s;
    assign dtc_unused_s = ^{dtc_enable, dtc_done};
    assign elig_s = irq_flag & irq_enable & {NUM_IRQ{~cpu_int_mask}};
`endif

    irq_prio_enc #(
        .N     (NUM_IRQ),
        .IDX_W (ID_W)
    ) u_prio (
        .req   (elig_s),
        .valid (win_valid_s),
        .idx   (win_id_s)
    );

    // Next-state logic; outputs are derived from the next state so they register cleanly.
    always_comb begin
        state_d     = state_q;
        active_id_d = active_id_q;
        case (state_q)
            ST_IDLE: begin
                if (win_valid_s) begin
                    active_id_d = win_id_s;
`ifdef IRQ_ACCEPT_DTC_EN
                    state_d = dtc_enable[win_id_s] ? ST_DTC_REQ : ST_CPU_REQ;
`else
                    state_d = ST_CPU_REQ;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CPU_REQ: begin
                if (cpu_int_ack) begin
                    state_d = ST_CPU_ACK;
                end else if (!irq_flag[active_id_q] || !irq_enable[active_id_q] || cpu_int_mask) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_CPU_REQ;
                end
            end
            ST_CPU_ACK: state_d = ST_IDLE;
`ifdef IRQ_ACCEPT_DTC_EN
            ST_DTC_REQ: state_d = dtc_done ? ST_DTC_ACK : ST_DTC_REQ;
            ST_DTC_ACK: state_d = ST_IDLE;
`endif
            default: state_d = ST_IDLE;
        endcase

        int_req_d      = (state_d == ST_CPU_REQ);
        int_vec_d      = int_req_d ? vec_of(active_id_d) : {VEC_W{1'b0}};
        exc_handling_d = (state_d == ST_CPU_ACK);
        busy_d         = (state_d != ST_IDLE);
`ifdef IRQ_ACCEPT_DTC_EN
        dtc_req_d      = (state_d == ST_DTC_REQ);
        dtc_activate_d = (state_d == ST_DTC_ACK);
`else
        dtc_req_d      = 1'b0;
        dtc_activate_d = 1'b0;
`endif
    end

    // State and output registers; reset drops any in-flight request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            active_id_q    <= {ID_W{1'b0}};
            int_req_q      <= 1'b0;
            int_vec_q      <= {VEC_W{1'b0}};
            dtc_req_q      <= 1'b0;
            exc_handling_q <= 1'b0;
            dtc_activate_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            active_id_q    <= active_id_d;
            int_req_q      <= int_req_d;
            int_vec_q      <= int_vec_d;
            dtc_req_q      <= dtc_req_d;
            exc_handling_q <= exc_handling_d;
            dtc_activate_q <= dtc_activate_d;
            busy_q         <= busy_d;
        end
    end

    assign int_req      = int_req_q;
    assign int_vec      = int_vec_q;
    assign dtc_req      = dtc_req_q;
    assign exc_handling = exc_handling_q;
    assign dtc_activate = dtc_activate_q;
    assign active_id    = active_id_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_irq_accept_ctrl.sv
// Directed self-checking bench for irq_accept_ctrl (default 8 channels, vector base 64).
module tb_irq_accept_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] irq_flag, irq_enable, dtc_enable;
    logic       cpu_int_mask, cpu_int_ack, dtc_done;
    logic       int_req, dtc_req, exc_handling, dtc_activate, busy;
    logic [7:0] int_vec;
    logic [2:0] active_id;

    int checks = 0;
    int errors = 0;

    irq_accept_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .irq_flag     (irq_flag),
        .irq_enable   (irq_enable),
        .dtc_enable   (dtc_enable),
        .cpu_int_mask (cpu_int_mask),
        .cpu_int_ack  (cpu_int_ack),
        .dtc_done     (dtc_done),
        .int_req      (int_req),
        .int_vec      (int_vec),
        .dtc_req      (dtc_req),
        .exc_handling (exc_handling),
        .dtc_activate (dtc_activate),
        .active_id    (active_id),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_req"}, {31'd0, int_req}, 32'd0);
        chk({tag, "_dreq"}, {31'd0, dtc_req}, 32'd0);
        chk({tag, "_exc"}, {31'd0, exc_handling}, 32'd0);
        chk({tag, "_dact"}, {31'd0, dtc_activate}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        irq_flag = 8'h00; irq_enable = 8'hFF; dtc_enable = 8'h00;
        cpu_int_mask = 1'b0; cpu_int_ack = 1'b0; dtc_done = 1'b0;
        step(); step();
        chk_idle("rst");
        chk("rst_id", {29'd0, active_id}, 32'd0);
        chk("rst_vec", {24'd0, int_vec}, 32'd0);
        rst = 1'b0;
        step();

        // Async reset in the middle of a CPU request on channel 3.
        irq_flag = 8'b0000_1000;
        step();
        chk("a_req", {31'd0, int_req}, 32'd1);
        chk("a_id", {29'd0, active_id}, 32'd3);
        chk("a_vec", {24'd0, int_vec}, 32'd67);
        #2 rst = 1'b1;
        #1;
        chk_idle("a_async");
        chk("a_async_id", {29'd0, active_id}, 32'd0);
        chk("a_async_vec", {24'd0, int_vec}, 32'd0);
        irq_flag = 8'h00;
        step();
        rst = 1'b0;
        step(); step();
        chk_idle("a_hold");

        // Priority: channels 2 and 5 pending, 2 wins; cleared flag then exposes 5.
        irq_flag = 8'b0010_0100;
        step();
        chk("b_req", {31'd0, int_req}, 32'd1);
        chk("b_id", {29'd0, active_id}, 32'd2);
        chk("b_vec", {24'd0, int_vec}, 32'd66);
        step();
        chk("b_stable", {24'd0, int_vec}, 32'd66);
        cpu_int_ack = 1'b1;
        step();
        chk("b_ack_req", {31'd0, int_req}, 32'd0);
        chk("b_exc", {31'd0, exc_handling}, 32'd1);
        cpu_int_ack = 1'b0;
        irq_flag = 8'b0010_0000;
        step();
        chk_idle("b_post");
        step();
        chk("b2_id", {29'd0, active_id}, 32'd5);
        chk("b2_vec", {24'd0, int_vec}, 32'd69);
        // Higher-priority arrival does not preempt channel 5.
        irq_flag = 8'b0010_0010;
        step();
        chk("b2_nopre", {29'd0, active_id}, 32'd5);
        cpu_int_ack = 1'b1;
        step();
        chk("b2_exc", {31'd0, exc_handling}, 32'd1);
        cpu_int_ack = 1'b0;
        irq_flag = 8'b0000_0010;
        step();
        chk_idle("b2_post");
        step();
        chk("b3_id", {29'd0, active_id}, 32'd1);
        chk("b3_vec", {24'd0, int_vec}, 32'd65);
        // Mask alone cancels a CPU request with no pulse.
        cpu_int_mask = 1'b1;
        step();
        chk_idle("b3_mask");
        cpu_int_mask = 1'b0;
        irq_flag = 8'h00;
        step();

        // Flag dropped without ack: cancel, no pulse.
        irq_flag = 8'b0001_0000;
        step();
        chk("c_id", {29'd0, active_id}, 32'd4);
        chk("c_req", {31'd0, int_req}, 32'd1);
        irq_flag = 8'h00;
        step();
        chk_idle("c_cancel");
        cpu_int_ack = 1'b1;
        step();
        chk_idle("c_stray_ack");
        cpu_int_ack = 1'b0;

        // Ack and mask on the same cycle: ack wins.
        irq_flag = 8'b0100_0000;
        step();
        chk("d_id", {29'd0, active_id}, 32'd6);
        cpu_int_ack = 1'b1;
        cpu_int_mask = 1'b1;
        step();
        chk("d_exc", {31'd0, exc_handling}, 32'd1);
        chk("d_req", {31'd0, int_req}, 32'd0);
        cpu_int_ack = 1'b0;
        cpu_int_mask = 1'b0;
        irq_flag = 8'h00;
        step();
        chk_idle("d_post");

        // DTC-routed channel 1 under CPU mask.
        cpu_int_mask = 1'b1;
        dtc_enable = 8'b0000_0010;
        irq_flag = 8'b0000_0010;
        step();
`ifdef IRQ_ACCEPT_DTC_EN
        chk("e_dreq", {31'd0, dtc_req}, 32'd1);
        chk("e_id", {29'd0, active_id}, 32'd1);
        cpu_int_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            cpu_int_ack = 1'b0;
            chk("e_wait_dreq", {31'd0, dtc_req}, 32'd1);
            chk("e_wait_req", {31'd0, int_req}, 32'd0);
        end
        dtc_done = 1'b1;
        step();
        chk("e_dreq_off", {31'd0, dtc_req}, 32'd0);
        chk("e_dact", {31'd0, dtc_activate}, 32'd1);
        chk("e_req", {31'd0, int_req}, 32'd0);
        dtc_done = 1'b0;
        irq_flag = 8'h00;
        step();
        chk_idle("e_post");
`else
        chk_idle("e_masked");
        cpu_int_mask = 1'b0;
        step();
        chk("e_req", {31'd0, int_req}, 32'd1);
        chk("e_dreq", {31'd0, dtc_req}, 32'd0);
        chk("e_id", {29'd0, active_id}, 32'd1);
        chk("e_vec", {24'd0, int_vec}, 32'd65);
        dtc_done = 1'b1;
        step();
        chk("e_done_ign", {31'd0, int_req}, 32'd1);
        dtc_done = 1'b0;
        cpu_int_ack = 1'b1;
        step();
        chk("e_exc", {31'd0, exc_handling}, 32'd1);
        chk("e_dact", {31'd0, dtc_activate}, 32'd0);
        cpu_int_ack = 1'b0;
        irq_flag = 8'h00;
        step();
        chk_idle("e_post");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/irq_accept_ctrl.md
# irq_accept_ctrl

Interrupt acceptance controller on the CPU side of the external-interrupt path. It consumes the per-channel latched IRQ request flags (ISR bits) produced by the IRQ pin detectors. It resolves fixed priority, then either presents a vector to the CPU via a req/ack handshake or hands the request to the DTC. It issues the one-cycle `exc_handling` / `dtc_activate` pulses that the IRQ clear logic uses to clear the accepted flag.

## Interface
Parameters:
- `NUM_IRQ`, 8: number of IRQ channels (2..16).
- `VEC_BASE`, 64: vector number of channel 0; channel i uses `VEC_BASE+i`.
- `VEC_W`, 8: vector width; `VEC_BASE+NUM_IRQ-1` must fit.

Ports:
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst` in 1: reset. **Asynchronous, active-high.**
- `irq_flag` in NUM_IRQ: latched request flags (ISR).
- `irq_enable` in NUM_IRQ: per-channel enable (IER).
- `dtc_enable` in NUM_IRQ: per-channel DTC routing (DTCER).
- `cpu_int_mask` in 1: CPU interrupt mask bit. 1 blocks the CPU path only.
- `cpu_int_ack` in 1: CPU accepts the presented vector.
- `dtc_done` in 1: DTC transfer complete.
- `int_req` out 1: interrupt request to the CPU (level).
- `int_vec` out VEC_W: vector, valid while `int_req`=1.
- `dtc_req` out 1: activation request to the DTC (level).
- `exc_handling` out 1: one-cycle pulse, CPU accepted `active_id`.
- `dtc_activate` out 1: one-cycle pulse, DTC finished `active_id`.
- `active_id` out $clog2(NUM_IRQ): channel being serviced.
- `busy` out 1: FSM not in IDLE.

## Operation
- Eligibility:
  - `elig[i] = irq_flag[i] & irq_enable[i] & (dtc_enable[i] | ~cpu_int_mask)`.
  - The lowest index wins.
- FSM states: IDLE, CPU_REQ, DTC_REQ, CPU_ACK, DTC_ACK.
- IDLE:
  - If any `elig`, register the winner into `active_id`.
  - Go to DTC_REQ if `dtc_enable[winner]`, else go to CPU_REQ.
- CPU_REQ:
  - `int_req`=1 and `int_vec=VEC_BASE+active_id`, both held stable.
  - If `cpu_int_ack`=1, go to CPU_ACK. Ack wins over a simultaneous cancel.
  - Otherwise, if `irq_flag[active_id]`=0, `irq_enable[active_id]`=0 or `cpu_int_mask`=1, cancel and go to IDLE. No pulse is issued.
- CPU_ACK: `exc_handling`=1 for this cycle only, then go to IDLE.
- DTC_REQ:
  - `dtc_req`=1.
  - Not cancellable. Waits for `dtc_done` indefinitely and ignores the mask.
  - On `dtc_done`, go to DTC_ACK.
- DTC_ACK: `dtc_activate`=1 for this cycle only, then go to IDLE.
- `cpu_int_ack` or `dtc_done` arriving in a state that does not expect it is ignored.
- A higher-priority request arriving during service does not preempt. It is arbitrated in the next IDLE.
- Reset, asserted at any time including mid-handshake:
  - All outputs are 0 and `active_id` is 0.
  - The state returns to IDLE.
  - Any in-flight request is dropped without a pulse.

## Timing
- Decision latency: 1 cycle. When `elig` is seen in IDLE at edge N, `int_req`/`dtc_req` is high from after edge N.
- All outputs are registered. No combinational path from input to output.
- `cpu_int_ack` sampled at edge M gives `int_req`=0 and `exc_handling`=1 during cycle M..M+1. The FSM is back in IDLE after M+1.
- Minimum back-to-back service: 3 cycles (IDLE, REQ, ACK).
- Because of the ACK cycle, the cleared flag is observed before re-arbitration.

## Configuration
- `IRQ_ACCEPT_DTC_EN` defined:
  - DTC path present, as described above.
- `IRQ_ACCEPT_DTC_EN` undefined:
  - `dtc_enable` is ignored (treated as all-0).
  - DTC_REQ and DTC_ACK are not built.
  - `dtc_req` and `dtc_activate` are tied 0.
  - `dtc_done` is unused.
  - Every eligible request goes to CPU_REQ.

## Structure
- Shared package `irq_pkg`:
  - State enum `irq_acc_state_t`.
  - Default `NUM_IRQ`, `VEC_BASE` and `VEC_W` constants.
- Sub-module `irq_prio_enc`:
  - Parameterised lowest-index priority encoder.
  - Outputs `valid` and the encoded index.
  - Instantiated once on `elig`.

## Test plan
- Reset mid CPU_REQ (`int_req`=1, id 3): assert `rst` asynchronously → all outputs 0 immediately. After release, with flags cleared, IDLE is held.
- `irq_flag`=8'b0010_0100, all enabled, mask=0, no DTC → `active_id`=2, `int_vec`=66. Ack → `exc_handling` pulse 1 cycle. Clear bit 2 → next service is id 5, `int_vec`=69.
- id 4 in CPU_REQ, `irq_flag[4]` dropped without ack → `int_req` falls the next cycle, no `exc_handling`, `busy`=0.
- `cpu_int_ack` and mask rise on the same cycle in CPU_REQ → ack wins, `exc_handling`=1.
- Mask=1, `irq_flag[1]`=1 with `dtc_enable[1]`=1 → `dtc_req`=1. After `dtc_done` 5 cycles later → `dtc_activate` pulse 1 cycle, `int_req` never asserted.
- Build without `IRQ_ACCEPT_DTC_EN`, same stimulus with mask=0 → CPU path taken, `dtc_req` stays 0.
